// File: rtl/seven_segment_scanner_pkg.sv
// Purpose: seven-segment pattern constants, segment bus bit order and scan phase type shared by display blocks.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package seven_segment_scanner_pkg;

   // Segment bus bit order: {a,b,c,d,e,f,g,dp}; bit 7 = a, bit 0 = dp.
   localparam int SEG_W      = 8;
   localparam int SEG_DP_BIT = 0;

   // Active-high abcdefg patterns for each hex digit.
   localparam logic [6:0] SEG_HEX_0 = 7'b1111110;
   localparam logic [6:0] SEG_HEX_1 = 7'b0110000;
   localparam logic [6:0] SEG_HEX_2 = 7'b1101101;
   localparam logic [6:0] SEG_HEX_3 = 7'b1111001;
   localparam logic [6:0] SEG_HEX_4 = 7'b0110011;
   localparam logic [6:0] SEG_HEX_5 = 7'b1011011;
   localparam logic [6:0] SEG_HEX_6 = 7'b1011111;
   localparam logic [6:0] SEG_HEX_7 = 7'b1110000;
   localparam logic [6:0] SEG_HEX_8 = 7'b1111111;
   localparam logic [6:0] SEG_HEX_9 = 7'b1111011;
   localparam logic [6:0] SEG_HEX_A = 7'b1110111;
   localparam logic [6:0] SEG_HEX_B = 7'b0011111;
   localparam logic [6:0] SEG_HEX_C = 7'b1001110;
   localparam logic [6:0] SEG_HEX_D = 7'b0111101;
   localparam logic [6:0] SEG_HEX_E = 7'b1001111;
   localparam logic [6:0] SEG_HEX_F = 7'b1000111;
   localparam logic [6:0] SEG_BLANK = 7'b0000000;

   // Within a digit slot: leading anti-ghosting gap, then the lit portion.
   typedef enum logic {
      PH_BLANK = 1'b0,
      PH_SHOW  = 1'b1
   } phase_t;

endpackage

// File: rtl/hex_to_seven_segment.sv
// Purpose: combinational 4-bit hex to active-high abcdefg segment decode.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
module hex_to_seven_segment
   import seven_segment_scanner_pkg::*;
(
   input  logic [3:0] hex,
   output logic [6:0] seg
);

   // Table lookup of the glyph for each nibble value.
   always_comb begin
      seg = SEG_BLANK;
      case (hex)
         4'h0: seg = SEG_HEX_0;
         4'h1: seg = SEG_HEX_1;
         4'h2: seg = SEG_HEX_2;
         4'h3: seg = SEG_HEX_3;
         4'h4: seg = SEG_HEX_4;
         4'h5: seg = SEG_HEX_5;
         4'h6: seg = SEG_HEX_6;
         4'h7: seg = SEG_HEX_7;
         4'h8: seg = SEG_HEX_8;
         4'h9: seg = SEG_HEX_9;
         4'hA: seg = SEG_HEX_A;
         4'hB: seg = SEG_HEX_B;
         4'hC: seg = SEG_HEX_C;
         4'hD: seg = SEG_HEX_D;
         4'hE: seg = SEG_HEX_E;
         4'hF: seg = SEG_HEX_F;
      endcase
   end

endmodule

// File: rtl/seven_segment_scanner.sv
// Purpose: time-multiplexed N-digit seven-segment scanner with per-slot blanking gap, frame snapshot and leading-zero blanking.
// Latency: outputs registered, pins follow the internal scan state one cycle later.
// Backpressure: none; free-running scan, inputs sampled only at frame start.
module seven_segment_scanner
   import seven_segment_scanner_pkg::*;
#(
   parameter int N_DIGITS       = 4,
   parameter int REFRESH_DIV    = 3000,
   parameter int BLANK_CYCLES   = 300,
   parameter bit SEG_ACTIVE_LOW = 1'b0,
   parameter bit DIG_ACTIVE_LOW = 1'b1
) (
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic [4*N_DIGITS-1:0]   number,
   input  logic [N_DIGITS-1:0]     dots,
   input  logic                    lz_blank,
   output logic [SEG_W-1:0]        segments,
   output logic [N_DIGITS-1:0]     digit,
   output logic                    frame_start
);

   localparam int CNT_W = $clog2(REFRESH_DIV);
   localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

   // Inactive pin levels; XOR with these converts active-high values to pin polarity.
   localparam logic [SEG_W-1:0]    SEG_OFF = {SEG_W{SEG_ACTIVE_LOW}};
   localparam logic [N_DIGITS-1:0] DIG_OFF = {N_DIGITS{DIG_ACTIVE_LOW}};

   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic [4*N_DIGITS-1:0]  number_sh_q, number_sh_d;
   logic [N_DIGITS-1:0]    dots_sh_q, dots_sh_d;
   logic                   lz_sh_q, lz_sh_d;
   logic [SEG_W-1:0]       segments_q, segments_d;
   logic [N_DIGITS-1:0]    digit_q, digit_d;
   logic                   frame_start_q, frame_start_d;

   logic                   cnt_wrap;
   logic                   snap;
   phase_t                 phase;
   logic [3:0]             cur_nib;
   logic [6:0]             dec_seg;
   logic                   cur_dot;
   logic                   suppress;
   logic [N_DIGITS-1:0]    zero_from;
   logic [SEG_W-1:0]       seg_raw;
   logic [N_DIGITS-1:0]    dig_raw;

   hex_to_seven_segment u_dec (
      .hex (cur_nib),
      .seg (dec_seg)
   );

   // Slot counter, digit index and frame-start snapshot of the inputs.
   always_comb begin
      cnt_wrap = (cnt_q == CNT_W'(REFRESH_DIV - 1));
      cnt_d    = cnt_wrap ? '0 : cnt_q + CNT_W'(1);
      idx_d    = idx_q;
      if (cnt_wrap) begin
         idx_d = (idx_q == IDX_W'(N_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
      end
      snap        = (cnt_q == '0) && (idx_q == '0);
      number_sh_d = snap ? number   : number_sh_q;
      dots_sh_d   = snap ? dots     : dots_sh_q;
      lz_sh_d     = snap ? lz_blank : lz_sh_q;
   end

   // zero_from[i]: every nibble from i up to the most significant one is zero.
   always_comb begin
      zero_from             = '0;
      zero_from[N_DIGITS-1] = (number_sh_q[4*N_DIGITS-1 -: 4] == 4'h0);
      for (int i = N_DIGITS - 2; i >= 0; i--) begin
         zero_from[i] = zero_from[i+1] && (number_sh_q[4*i +: 4] == 4'h0);
      end
   end

   // Next pin values for the current slot position, converted to pin polarity.
   always_comb begin
      phase    = (cnt_q < CNT_W'(BLANK_CYCLES)) ? PH_BLANK : PH_SHOW;
      cur_nib  = number_sh_q[{idx_q, 2'b00} +: 4];
      cur_dot  = dots_sh_q[idx_q];
      suppress = lz_sh_q && (idx_q != '0) && zero_from[idx_q];
      seg_raw  = {dec_seg, cur_dot};
      dig_raw  = '0;
      dig_raw[idx_q] = 1'b1;
      if (phase == PH_BLANK) begin
         seg_raw = '0;
         dig_raw = '0;
      end else if (suppress) begin
         // A blanked leading zero keeps only its decimal point, if any.
         seg_raw             = {SEG_BLANK, 1'b0};
         seg_raw[SEG_DP_BIT] = cur_dot;
         if (!cur_dot) begin
            dig_raw = '0;
         end
      end
      segments_d    = seg_raw ^ SEG_OFF;
      digit_d       = dig_raw ^ DIG_OFF;
      frame_start_d = snap;
   end

   // State and output registers; async reset drives all pins inactive immediately.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q         <= '0;
         idx_q         <= '0;
         number_sh_q   <= '0;
         dots_sh_q     <= '0;
         lz_sh_q       <= 1'b0;
         segments_q    <= SEG_OFF;
         digit_q       <= DIG_OFF;
         frame_start_q <= 1'b0;
      end else begin
         cnt_q         <= cnt_d;
         idx_q         <= idx_d;
         number_sh_q   <= number_sh_d;
         dots_sh_q     <= dots_sh_d;
         lz_sh_q       <= lz_sh_d;
         segments_q    <= segments_d;
         digit_q       <= digit_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign segments    = segments_q;
   assign digit       = digit_q;
   assign frame_start = frame_start_q;

endmodule
